rr_token_arbiter: RTL and testbench



---
 rtl/rr_token_arbiter_if.sv | 23 ++
 rtl/rr_token_arbiter.sv | 117 +++++++++++
 tb/tb_rr_token_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_token_arbiter_if.sv
// Request/grant bundle between N clients and the round-robin token arbiter.
// The arbiter side uses the master modport; client request logic uses slave.
interface rr_token_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   ack;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout_pulse;

  modport master (
    input  req,
    output ack, grant_valid, grant_id, busy, timeout_pulse
  );

  modport slave (
    output req,
    input  ack, grant_valid, grant_id, busy, timeout_pulse
  );
endinterface

// File: rtl/rr_token_arbiter.sv
// Central IDLE/READY/BUSY token arbiter for N request/ack clients with a circular
// pointer, selectable skip-idle scan and an optional hold timeout with masking.
module rr_token_arbiter #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int SKIP_IDLE = 1,
  parameter int MAX_HOLD  = 16
) (
  input logic clk,
  input logic rst,
  rr_token_arbiter_if.master bus
);

  localparam int HW   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int SCAN = (SKIP_IDLE != 0) ? N : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

  logic [1:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_gid;
  logic [N-1:0]   r_ack;
  logic [N-1:0]   r_mask;
  logic [HW-1:0]  r_hold;
  logic           r_tpulse;

  logic [N-1:0]   w_elig;
  logic [N-1:0]   w_gid_oh;
  logic           w_req_g;
  logic [IDW-1:0] w_after_gid;
  logic [IDW-1:0] w_after_ptr;
  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_idx [N];

  assign w_elig      = bus.req & ~r_mask;
  assign w_gid_oh    = {{(N-1){1'b0}}, 1'b1} << r_gid;
  assign w_req_g     = |(bus.req & w_gid_oh);
  assign w_after_gid = (r_gid == LAST_ID) ? '0 : r_gid + 1'b1;
  assign w_after_ptr = (r_ptr == LAST_ID) ? '0 : r_ptr + 1'b1;

  // Circular scan order starting at the pointer, wrapped explicitly so no index reaches N.
  for (genvar g = 0; g < N; g++) begin : g_idx
    assign w_idx[g] = (int'(r_ptr) + g >= N) ? IDW'(int'(r_ptr) + g - N)
                                             : IDW'(int'(r_ptr) + g);
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int off = SCAN - 1; off >= 0; off--) begin
      if (w_elig[w_idx[off]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[off];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gid    <= '0;
      r_ack    <= '0;
      r_mask   <= '0;
      r_hold   <= '0;
      r_tpulse <= 1'b0;
    end else begin
      r_mask   <= r_mask & bus.req;
      r_tpulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_READY;
            r_gid   <= w_pick;
          end else if (SKIP_IDLE == 0) begin
            r_ptr <= w_after_ptr;
          end
        end
        S_READY: begin
          r_state <= S_BUSY;
          r_ack   <= w_gid_oh;
          r_hold  <= HW'(1);
        end
        S_BUSY: begin
          // A release on the timeout edge wins: no mask and no pulse.
          if (!w_req_g) begin
            r_state <= S_IDLE;
            r_ack   <= '0;
            r_ptr   <= w_after_gid;
          end else if (MAX_HOLD != 0 && r_hold == HOLD_MAX) begin
            r_state  <= S_IDLE;
            r_ack    <= '0;
            r_mask   <= (r_mask & bus.req) | w_gid_oh;
            r_tpulse <= 1'b1;
            r_ptr    <= w_after_gid;
          end else if (r_hold != '1) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack           = r_ack;
  assign bus.grant_valid   = (r_state != S_IDLE);
  assign bus.grant_id      = r_gid;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.timeout_pulse = r_tpulse;

endmodule

// File: tb/tb_rr_token_arbiter.sv
// Scoreboard bench for rr_token_arbiter: three configurations driven together,
// expected outputs from a transaction-level model queued and checked at negedge.
module tb_rr_token_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rr_token_arbiter_if #(.N(4), .IDW(2)) ifA ();
  rr_token_arbiter_if #(.N(3), .IDW(2)) ifB ();
  rr_token_arbiter_if #(.N(5), .IDW(3)) ifC ();

  rr_token_arbiter #(.N(4), .IDW(2), .SKIP_IDLE(1), .MAX_HOLD(4)) dutA (.clk(clk), .rst(rst), .bus(ifA.master));
  rr_token_arbiter #(.N(3), .IDW(2), .SKIP_IDLE(0), .MAX_HOLD(6)) dutB (.clk(clk), .rst(rst), .bus(ifB.master));
  rr_token_arbiter #(.N(5), .IDW(3), .SKIP_IDLE(1), .MAX_HOLD(0)) dutC (.clk(clk), .rst(rst), .bus(ifC.master));

  typedef struct packed {
    logic [15:0] ack;
    logic        gv;
    logic [3:0]  gid;
    logic        busy;
    logic        tp;
  } obs_t;

  // phase: 0 = waiting for a winner, 1 = winner announced, 2 = winner holding ack
  typedef struct {
    int          phase;
    int          gid;
    int          ptr;
    int          hold;
    logic [15:0] mask;
    logic [15:0] ack;
    logic        tp;
  } mdl_t;

  mdl_t mA, mB, mC;
  obs_t qA[$], qB[$], qC[$];
  logic [15:0] reqA = '0, reqB = '0, reqC = '0;
  int total = 0;
  int bad = 0;

  function automatic mdl_t modelStep(mdl_t m, logic [15:0] req, int n, int skip, int maxHold, logic r);
    mdl_t s = m;
    if (r) begin
      s.phase = 0; s.gid = 0; s.ptr = 0; s.hold = 0;
      s.mask = '0; s.ack = '0; s.tp = 1'b0;
      return s;
    end
    s.mask = m.mask & req;
    s.tp = 1'b0;
    if (m.phase == 0) begin
      for (int off = 0; off < (skip != 0 ? n : 1); off++) begin
        int k = (m.ptr + off) % n;
        if (req[k] && !m.mask[k]) begin
          s.phase = 1;
          s.gid = k;
          break;
        end
      end
      if (s.phase == 0 && skip == 0) s.ptr = (m.ptr + 1) % n;
    end else if (m.phase == 1) begin
      s.phase = 2;
      s.ack = 16'd1 << m.gid;
      s.hold = 1;
    end else begin
      if (!req[m.gid]) begin
        s.phase = 0; s.ack = '0; s.ptr = (m.gid + 1) % n;
      end else if (maxHold != 0 && m.hold == maxHold) begin
        s.phase = 0; s.ack = '0; s.ptr = (m.gid + 1) % n;
        s.mask[m.gid] = 1'b1;
        s.tp = 1'b1;
      end else begin
        s.hold = m.hold + 1;
      end
    end
    return s;
  endfunction

  function automatic obs_t expOf(mdl_t m);
    obs_t e;
    e.ack  = m.ack;
    e.gv   = (m.phase != 0);
    e.gid  = 4'(m.gid);
    e.busy = (m.phase != 0);
    e.tp   = m.tp;
    return e;
  endfunction

  function automatic logic [15:0] genReq(logic [15:0] cur, logic [15:0] ack, int n, int pRise, int pDropAck, int pDropWait);
    logic [15:0] nx = '0;
    for (int i = 0; i < n; i++) begin
      int roll = int'($urandom_range(99, 0));
      if (!cur[i])      nx[i] = (roll < pRise);
      else if (ack[i])  nx[i] = !(roll < pDropAck);
      else              nx[i] = !(roll < pDropWait);
    end
    return nx;
  endfunction

  task automatic applyStimulus(input logic r, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    #1;
    rst = r;
    reqA = a; reqB = b; reqC = c;
    ifA.req = a[3:0];
    ifB.req = b[2:0];
    ifC.req = c[4:0];
    mA = modelStep(mA, a, 4, 1, 4, r);
    mB = modelStep(mB, b, 3, 0, 6, r);
    mC = modelStep(mC, c, 5, 1, 0, r);
    qA.push_back(expOf(mA));
    qB.push_back(expOf(mB));
    qC.push_back(expOf(mC));
  endtask

  task automatic checkOutput(input string name, input obs_t exp, input obs_t act);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s outputs: got ack=%h gv=%b id=%0d busy=%b tp=%b, want ack=%h gv=%b id=%0d busy=%b tp=%b",
               name, act.ack, act.gv, act.gid, act.busy, act.tp, exp.ack, exp.gv, exp.gid, exp.busy, exp.tp);
    end
    total++;
    if (!$onehot0(act.ack)) begin
      bad++;
      $display("[TB] FAIL %s ack_onehot: got ack=%h, want at most one bit set", name, act.ack);
    end
  endtask

  always @(negedge clk) begin
    if (qA.size() > 0)
      checkOutput("A", qA.pop_front(), {16'(ifA.ack), ifA.grant_valid, 4'(ifA.grant_id), ifA.busy, ifA.timeout_pulse});
    if (qB.size() > 0)
      checkOutput("B", qB.pop_front(), {16'(ifB.ack), ifB.grant_valid, 4'(ifB.grant_id), ifB.busy, ifB.timeout_pulse});
    if (qC.size() > 0)
      checkOutput("C", qC.pop_front(), {16'(ifC.ack), ifC.grant_valid, 4'(ifC.grant_id), ifC.busy, ifC.timeout_pulse});
  end

  initial begin
    int ageA[4];
    logic [15:0] a;
    bit resetDone;
    int budget;

    ifA.req = '0; ifB.req = '0; ifC.req = '0;
    repeat (2) applyStimulus(1'b1, 16'h0, 16'h0, 16'h0);

    // Single requester on A: client 1 holds then releases, then 3 wins from ptr=2.
    for (int c = 0; c < 14; c++) begin
      a = (c < 4) ? 16'h2 : ((c >= 6 && c < 10) ? 16'h9 : 16'h0);
      applyStimulus(1'b0, a, genReq(reqB, mB.ack, 3, 30, 25, 5), genReq(reqC, mC.ack, 5, 30, 25, 5));
    end

    // All A clients requesting, each dropping 3 cycles after its ack; reset while client 2 holds.
    for (int i = 0; i < 4; i++) ageA[i] = 0;
    resetDone = 1'b0;
    budget = 0;
    while (!resetDone && budget < 200) begin
      budget++;
      if (mA.ack[3:0] == 4'b0100 && ageA[2] >= 1) begin
        applyStimulus(1'b1, 16'hF, genReq(reqB, mB.ack, 3, 30, 25, 5), genReq(reqC, mC.ack, 5, 30, 25, 5));
        #1;
        total++;
        if (ifA.ack !== 4'b0000) begin
          bad++;
          $display("[TB] FAIL async_reset_ack: got %b, want 0000 before any clock edge", ifA.ack);
        end
        applyStimulus(1'b1, 16'hF, 16'h0, 16'h0);
        resetDone = 1'b1;
      end else begin
        a = 16'hF;
        for (int i = 0; i < 4; i++) begin
          ageA[i] = mA.ack[i] ? ageA[i] + 1 : 0;
          if (ageA[i] >= 3) a[i] = 1'b0;
        end
        applyStimulus(1'b0, a, genReq(reqB, mB.ack, 3, 30, 25, 5), genReq(reqC, mC.ack, 5, 30, 25, 5));
      end
    end
    if (!resetDone) begin
      total++;
      bad++;
      $display("[TB] FAIL reset_window: got no grant to client 2 within %0d cycles, want one", budget);
    end
    for (int c = 0; c < 30; c++) begin
      a = 16'hF;
      for (int i = 0; i < 4; i++) begin
        ageA[i] = mA.ack[i] ? ageA[i] + 1 : 0;
        if (ageA[i] >= 3) a[i] = 1'b0;
      end
      applyStimulus(1'b0, a, genReq(reqB, mB.ack, 3, 30, 25, 5), genReq(reqC, mC.ack, 5, 30, 25, 5));
    end

    // Randomized traffic with long holds (timeouts) and the occasional reset.
    for (int c = 0; c < 2000; c++) begin
      applyStimulus(($urandom_range(299, 0) == 0),
                    genReq(reqA, mA.ack, 4, 30, 20, 5),
                    genReq(reqB, mB.ack, 3, 30, 12, 5),
                    genReq(reqC, mC.ack, 5, 30, 25, 5));
    end

    @(negedge clk);
    #2;
    total++;
    if (qA.size() + qB.size() + qC.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", qA.size() + qB.size() + qC.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
